bcd_scan_display: RTL
=====================

// Module: bcd_scan_display
// PURPOSE
//  Downstream consumer of the counter stage. Snapshots a two-digit BCD count
//  (tens from the 4-bit binary counter, units from the decade counter) and
//  drives one multiplexed common-anode 7-segment pair for board display.
//  Double-buffered so digits never tear mid-frame. Flags non-BCD codes.
// PARAMETERS
//  SCAN_DIV        4  clock cycles per digit slot; legal range >=2
//  SEG_ACTIVE_LOW  1  1: seg lit = 0; 0: seg lit = 1
// PORTS
//  clk        in   1  system clock, rising edge
//  RST        in   1  asynchronous, active-low reset
//  EN         in   1  scan/load enable; 0 freezes all state
//  load       in   1  capture strobe for tens/units
//  tens       in   4  tens digit code
//  units      in   4  units digit code
//  seg        out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  an         out  2  digit select, active-low; an[0]=units, an[1]=tens
//  frame_tick out  1  1-cycle pulse at each frame start (commit point)
//  err        out  1  committed pair contains a code >9
// BEHAVIOUR
//  - RST low: immediately clears shadow, display, prescaler, ptr, err,
//    frame_tick. an=2'b11; seg = all segments off. Applies mid-frame too.
//  - Shadow: load&EN at the clock edge captures {tens,units}. Last load wins.
//  - Prescaler pc counts 0..SCAN_DIV-1 while EN. At pc=SCAN_DIV-1, pc wraps
//    to 0 and ptr toggles. ptr 0 = units slot, ptr 1 = tens slot.
//  - Commit: on the edge where ptr goes 1->0, shadow is copied to display
//    and frame_tick=1 in the following cycle. If load&EN occurs on the same
//    edge, the live tens/units inputs are committed (bypass), not the old shadow.
//  - Outputs are registered. an/seg reflect (ptr,pc) one cycle later.
//    During pc==0 of every slot, an=2'b11 (anti-ghost blank).
//    Otherwise the selected an bit is 0 and seg holds that digit's pattern.
//  - Decode, active-high (inverted when SEG_ACTIVE_LOW=1):
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//    any code 10..15 = 79 ("E").
//  - err is updated at commit only. Set if either committed digit is >9;
//    cleared when a valid pair commits.
//  - EN=0: pc, ptr, shadow, display and outputs hold. frame_tick forced 0.
//  - Post-reset: the first frame displays 00. First frame_tick appears after
//    2*SCAN_DIV enabled cycles.
// CONFIGURATION
//  - LZ_BLANK_EN defined: if the committed tens digit is 0, the tens slot
//    keeps an[1]=1 and seg=all off. The units digit is always shown.
//    err is unaffected.
//  - LZ_BLANK_EN undefined: tens 0 displays as "0" (3F).
// TESTING (SCAN_DIV=4, SEG_ACTIVE_LOW=1)
//  - Reset: hold RST low then release, EN=1.
//    -> an=11 and seg=7F during reset. After release, units slot shows
//    seg=40 ("0"), an=10. frame_tick first pulses 8 cycles after release.
//  - Load tens=4, units=7 mid-frame.
//    -> display is unchanged until the next frame_tick.
//    -> then units slot seg=78, an=10; tens slot seg=19, an=01. err=0.
//  - Load units=12 (0xC).
//    -> after commit, units slot seg=06 ("E") and err=1.
//    -> next load of 3/5 commits and clears err.
//  - Drop EN to 0 for 20 cycles mid-slot.
//    -> an, seg, ptr and pc are frozen; no frame_tick.
//    -> resume continues from the same pc.
//  - Assert load on the commit edge with 9/1.
//    -> 9/1 is displayed in that same frame (bypass).
//  - Assert RST mid-tens-slot.
//    -> an=11 immediately, without waiting for clk. Display returns to 00.
//    With LZ_BLANK_EN, the tens slot stays dark for tens=0.

Source files
------------

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_display
//  Description : Two-digit multiplexed common-anode 7-segment driver.
//                A shadow register captures {tens,units} on load&EN. The
//                shadow is copied to the display register once per frame,
//                on the edge where the scan pointer wraps from the tens slot
//                back to the units slot. Because the copy happens only
//                there, the digits never change partway through a frame.
//                err flags a committed digit above 9.
//  Options     : LZ_BLANK_EN (macro)
//                When defined, a committed tens digit of 0 is not shown:
//                the tens anode stays off and all segments stay dark.
//  Parameters  : SCAN_DIV       - clock cycles per digit slot (>= 2)
//                SEG_ACTIVE_LOW - 1: a lit segment is driven 0
//  Ports       : clk        - system clock, rising edge
//                RST        - asynchronous reset, active low
//                EN         - scan/load enable; 0 freezes all state
//                load       - capture strobe for tens/units
//                tens       - tens digit code
//                units      - units digit code
//                seg        - {g,f,e,d,c,b,a}, registered
//                an         - digit select, active low; [0]=units, [1]=tens
//                frame_tick - single-cycle pulse after each commit
//                err        - committed pair contains a code above 9
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       EN,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick,
    output logic       err
);

    localparam int              PC_W    = $clog2(SCAN_DIV);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_t;

    slot_t           slot, slot_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [7:0]      shadow, shadow_nxt;   // {tens, units}
    logic [7:0]      disp, disp_nxt;       // {tens, units}
    logic [6:0]      seg_nxt;
    logic [1:0]      an_nxt;
    logic            err_nxt;
    logic            ft_nxt;

    // Segment pattern for one digit. Codes 10..15 all show "E".
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h79;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            slot       <= SLOT_UNITS;
            pc         <= '0;
            shadow     <= '0;
            disp       <= '0;
            seg        <= SEG_OFF;
            an         <= 2'b11;
            err        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            slot       <= slot_nxt;
            pc         <= pc_nxt;
            shadow     <= shadow_nxt;
            disp       <= disp_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            err        <= err_nxt;
            frame_tick <= ft_nxt;
        end
    end

    always_comb begin
        slot_nxt   = slot;
        pc_nxt     = pc;
        shadow_nxt = shadow;
        disp_nxt   = disp;
        seg_nxt    = seg;
        an_nxt     = an;
        err_nxt    = err;
        ft_nxt     = 1'b0;

        if (EN) begin
            if (load) begin
                shadow_nxt = {tens, units};
            end

            if (pc == PC_LAST) begin
                pc_nxt   = '0;
                slot_nxt = (slot == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
            end else begin
                pc_nxt = pc + PC_W'(1);
            end

            // Commit on the tens->units wrap. shadow_nxt already holds a
            // same-edge load, so a load on this edge is displayed in the
            // frame that starts here rather than one frame later.
            if ((pc == PC_LAST) && (slot == SLOT_TENS)) begin
                disp_nxt = shadow_nxt;
                err_nxt  = (shadow_nxt[7:4] > 4'd9) || (shadow_nxt[3:0] > 4'd9);
                ft_nxt   = 1'b1;
            end

            // Outputs follow the current (slot, pc) one cycle later and use
            // the display contents from before any commit on this edge.
            // The first cycle of every slot is blanked to avoid ghosting
            // while the anodes switch over.
            if (pc == '0) begin
                an_nxt  = 2'b11;
                seg_nxt = SEG_OFF;
            end else if (slot == SLOT_UNITS) begin
                an_nxt  = 2'b10;
                seg_nxt = decode(disp[3:0]);
            end else begin
`ifdef LZ_BLANK_EN
                if (disp[7:4] == 4'd0) begin
                    an_nxt  = 2'b11;
                    seg_nxt = SEG_OFF;
                end else begin
                    an_nxt  = 2'b01;
                    seg_nxt = decode(disp[7:4]);
                end
`else
                an_nxt  = 2'b01;
                seg_nxt = decode(disp[7:4]);
`endif
            end
        end
    end

endmodule
`default_nettype wire
